// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the instruction-fetch program counter: branch condition
// modes, fetch FSM states and the branch-condition decode helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_ZERO   = 2'b01,
    BR_NZERO  = 2'b10,
    BR_NEG    = 2'b11
  } branch_mode_t;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  function automatic logic branch_cond(branch_mode_t mode, logic is_zero, logic is_neg);
    logic res;
    case (mode)
      BR_ALWAYS: res = 1'b1;
      BR_ZERO:   res = is_zero;
      BR_NZERO:  res = !is_zero;
      BR_NEG:    res = is_neg;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Decode-side bundle of the fetch PC unit: branch/call/ret controls in,
// fetch address and status out. master = decode, slave = fetch unit.
interface fetch_pc_unit_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CMP_W = 8,
  parameter int unsigned CNT_W = 16
) ();
  logic             halt;
  logic             stall;
  logic             branchsig;
  logic [1:0]       branchmode;
  logic             branchrel;
  logic [PC_W-1:0]  BranchOut;
  logic [CMP_W-1:0] cmp;
  logic             call;
  logic             ret;
  logic [PC_W-1:0]  core;
  logic             fetch_valid;
  logic             taken;
  logic             halted;
  logic [CNT_W-1:0] fetch_cnt;
  logic             ras_err;

  modport master (
    output halt, stall, branchsig, branchmode, branchrel, BranchOut, cmp, call, ret,
    input  core, fetch_valid, taken, halted, fetch_cnt, ras_err
  );

  modport slave (
    input  halt, stall, branchsig, branchmode, branchrel, BranchOut, cmp, call, ret,
    output core, fetch_valid, taken, halted, fetch_cnt, ras_err
  );
endinterface

// File: rtl/fetch_pc_unit_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry;
// overflow/underflow flag the offending push/pop in the same cycle.
module fetch_ras #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  logic [PC_W-1:0] mem [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q;
  logic [PtrW:0]   cnt_q;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (PtrW + 1)'(RAS_DEPTH));
  assign top       = mem[ptr_q - PtrW'(1)];
  assign overflow  = push && full;
  assign underflow = pop && empty;

  // ptr wraps naturally (power-of-2 depth), so a full push lands on the oldest slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PtrW'(1);
      if (!full) cnt_q <= cnt_q + (PtrW + 1)'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PtrW'(1);
      cnt_q <= cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch program counter with branches, stall and sticky halt.
// Define FETCH_RAS_EN to add a return-address stack for call/ret.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W      = 8,
  parameter int unsigned     CMP_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     CNT_W     = 16
) (
  input logic            clk,
  input logic            reset,
  fetch_pc_unit_if.slave bus
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of 2 and at least 2");
  end

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, target;
  logic            taken_q, redirect;
  logic [CNT_W-1:0] cnt_q;
  logic            run, cond;

  assign run    = (state_q == RUN);
  assign pc_inc = pc_q + PC_W'(1);
  assign target = bus.branchrel ? pc_q + bus.BranchOut : bus.BranchOut;
  assign cond   = branch_cond(branch_mode_t'(bus.branchmode), bus.cmp == '0,
                              bus.cmp[CMP_W-1]);

`ifdef FETCH_RAS_EN
  logic            ras_push, ras_pop, illegal;
  logic            ras_empty, ras_full, ras_overflow, ras_underflow;
  logic [PC_W-1:0] ras_top;
  logic            ras_err_q;

  fetch_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ras_err_q <= 1'b0;
    else        ras_err_q <= ras_err_q | illegal | ras_overflow | ras_underflow;
  end

  assign bus.ras_err = ras_err_q;
`else
  assign bus.ras_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (bus.halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    bus.fetch_valid = (state_q == RUN);
    bus.halted      = (state_q == HALTED);
  end

  // Next-PC priority: halt, stall, call+ret, ret, call, branch, increment
  always_comb begin
    pc_d     = pc_q;
    redirect = 1'b0;
`ifdef FETCH_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    illegal  = 1'b0;
`endif
    if (run && !bus.halt && !bus.stall) begin
      if (bus.call && bus.ret) begin
        pc_d = pc_inc;
`ifdef FETCH_RAS_EN
        illegal = 1'b1;
`endif
      end else if (bus.ret) begin
`ifdef FETCH_RAS_EN
        ras_pop = 1'b1;
        if (ras_empty) begin
          pc_d = pc_inc;
        end else begin
          pc_d     = ras_top;
          redirect = 1'b1;
        end
`else
        pc_d = pc_inc;
`endif
      end else if (bus.call) begin
        pc_d     = target;
        redirect = 1'b1;
`ifdef FETCH_RAS_EN
        ras_push = 1'b1;
`endif
      end else if (bus.branchsig && cond) begin
        pc_d     = target;
        redirect = 1'b1;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= redirect;
      if (run && (pc_d != pc_q) && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.core      = pc_q;
  assign bus.taken     = taken_q;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized
// traffic against a queue-based behavioural model.
module tb_fetch_pc_unit;
  localparam int PC_W  = 8;
  localparam int CMP_W = 8;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.PC_W(PC_W), .CMP_W(CMP_W), .CNT_W(CNT_W)) bus ();

  fetch_pc_unit #(
    .PC_W      (PC_W),
    .CMP_W     (CMP_W),
    .RESET_PC  (8'h00),
    .RAS_DEPTH (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: 0 boot, 1 run, 2 halted
  int m_pc, m_state, m_cnt;
  bit m_taken, m_err;
  int ras_q[$];

  function automatic void model_reset();
    m_pc = 0; m_state = 0; m_cnt = 0; m_taken = 0; m_err = 0;
    ras_q.delete();
  endfunction

  function automatic void model_step();
    int npc, tgt, off;
    bit cond;
    m_taken = 0;
    if (m_state == 0) begin m_state = 1; return; end
    if (m_state == 2) return;
    if (bus.halt) begin m_state = 2; return; end
    if (bus.stall) return;
    off = (bus.BranchOut >= 128) ? int'(bus.BranchOut) - 256 : int'(bus.BranchOut);
    tgt = bus.branchrel ? (m_pc + off + 256) % 256 : int'(bus.BranchOut);
    case (bus.branchmode)
      2'd0: cond = 1;
      2'd1: cond = (bus.cmp == 0);
      2'd2: cond = (bus.cmp != 0);
      default: cond = (bus.cmp >= 128);
    endcase
    if (bus.call && bus.ret) begin
      npc = (m_pc + 1) % 256;
`ifdef FETCH_RAS_EN
      m_err = 1;
`endif
    end else if (bus.ret) begin
`ifdef FETCH_RAS_EN
      if (ras_q.size() == 0) begin
        npc = (m_pc + 1) % 256; m_err = 1;
      end else begin
        npc = ras_q.pop_back(); m_taken = 1;
      end
`else
      npc = (m_pc + 1) % 256;
`endif
    end else if (bus.call) begin
`ifdef FETCH_RAS_EN
      if (ras_q.size() == DEPTH) begin
        void'(ras_q.pop_front()); m_err = 1;
      end
      ras_q.push_back((m_pc + 1) % 256);
`endif
      npc = tgt; m_taken = 1;
    end else if (bus.branchsig && cond) begin
      npc = tgt; m_taken = 1;
    end else begin
      npc = (m_pc + 1) % 256;
    end
    if (npc != m_pc && m_cnt < 65535) m_cnt++;
    m_pc = npc;
  endfunction

  function automatic logic [27:0] outs();
    return {bus.core, bus.taken, bus.fetch_valid, bus.halted, bus.fetch_cnt, bus.ras_err};
  endfunction

  function automatic logic [27:0] expv();
    return {8'(m_pc), m_taken, 1'(m_state == 1), 1'(m_state == 2), 16'(m_cnt), m_err};
  endfunction

  task automatic idle();
    bus.halt = 0; bus.stall = 0; bus.branchsig = 0; bus.branchmode = 2'd0;
    bus.branchrel = 0; bus.BranchOut = '0; bus.cmp = '0; bus.call = 0; bus.ret = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic goto_pc(input logic [7:0] pc);
    idle();
    bus.branchsig = 1; bus.BranchOut = pc;
    cycle();
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    model_reset();
    repeat (2) cycle();
    reset = 1;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    model_reset();
    repeat (2) cycle();
    total++;
    if (outs() !== 28'h0) begin
      $display("FAIL reset_values: got %h want %h", outs(), 28'h0); bad++;
    end
  endtask

  task automatic test_boot();
    int exp_core[4] = '{0, 0, 1, 2};
    int exp_vld[4]  = '{0, 1, 1, 1};
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle();
      total++;
      if (bus.core !== 8'(exp_core[i]) || bus.fetch_valid !== 1'(exp_vld[i])) begin
        $display("FAIL boot_seq[%0d]: got core=%h vld=%b want core=%h vld=%0d",
                 i, bus.core, bus.fetch_valid, 8'(exp_core[i]), exp_vld[i]);
        bad++;
      end
    end
  endtask

  task automatic test_branch_cond();
    goto_pc(8'h03);
    bus.branchsig = 1; bus.branchmode = 2'b01; bus.cmp = 8'h00; bus.BranchOut = 8'h7F;
    cycle();
    total++;
    if (bus.core !== 8'h7F || bus.taken !== 1'b1) begin
      $display("FAIL br_zero_taken: got core=%h taken=%b want core=7f taken=1",
               bus.core, bus.taken); bad++;
    end
    idle();
    cycle();
    total++;
    if (bus.core !== 8'h80 || bus.taken !== 1'b0) begin
      $display("FAIL taken_pulse: got core=%h taken=%b want core=80 taken=0",
               bus.core, bus.taken); bad++;
    end
    goto_pc(8'h03);
    bus.branchsig = 1; bus.branchmode = 2'b01; bus.cmp = 8'h01; bus.BranchOut = 8'h7F;
    cycle();
    total++;
    if (bus.core !== 8'h04 || bus.taken !== 1'b0) begin
      $display("FAIL br_zero_not_taken: got core=%h taken=%b want core=04 taken=0",
               bus.core, bus.taken); bad++;
    end
  endtask

  task automatic test_rel_wrap();
    goto_pc(8'h10);
    bus.branchsig = 1; bus.branchrel = 1; bus.BranchOut = 8'hF0;
    cycle();
    total++;
    if (bus.core !== 8'h00 || bus.taken !== 1'b1) begin
      $display("FAIL rel_neg_offset: got core=%h taken=%b want core=00 taken=1",
               bus.core, bus.taken); bad++;
    end
    goto_pc(8'hFF);
    cycle();
    total++;
    if (bus.core !== 8'h00) begin
      $display("FAIL pc_wrap: got core=%h want 00", bus.core); bad++;
    end
  endtask

  task automatic test_stall_halt();
    goto_pc(8'h30);
    bus.stall = 1; bus.branchsig = 1; bus.BranchOut = 8'h55;
    cycle();
    total++;
    if (bus.core !== 8'h30 || bus.taken !== 1'b0) begin
      $display("FAIL stall_hold: got core=%h taken=%b want core=30 taken=0",
               bus.core, bus.taken); bad++;
    end
    bus.stall = 0; bus.halt = 1;
    cycle();
    total++;
    if (bus.core !== 8'h30 || bus.halted !== 1'b1 || bus.fetch_valid !== 1'b0) begin
      $display("FAIL halt_enter: got core=%h halted=%b vld=%b want core=30 halted=1 vld=0",
               bus.core, bus.halted, bus.fetch_valid); bad++;
    end
    bus.halt = 0;
    repeat (2) cycle();
    total++;
    if (bus.core !== 8'h30 || bus.halted !== 1'b1 || bus.taken !== 1'b0) begin
      $display("FAIL halt_sticky: got core=%h halted=%b taken=%b want core=30 halted=1 taken=0",
               bus.core, bus.halted, bus.taken); bad++;
    end
    do_reset();
    cycle();
  endtask

  task automatic test_call_ret();
    goto_pc(8'h20);
    bus.call = 1; bus.BranchOut = 8'h40;
    cycle();
    total++;
    if (bus.core !== 8'h40 || bus.taken !== 1'b1) begin
      $display("FAIL call_jump: got core=%h taken=%b want core=40 taken=1",
               bus.core, bus.taken); bad++;
    end
    idle();
    bus.ret = 1;
    cycle();
    idle();
`ifdef FETCH_RAS_EN
    total++;
    if (bus.core !== 8'h21 || bus.taken !== 1'b1 || bus.ras_err !== 1'b0) begin
      $display("FAIL ret_pop: got core=%h taken=%b err=%b want core=21 taken=1 err=0",
               bus.core, bus.taken, bus.ras_err); bad++;
    end
    bus.call = 1;
    for (int i = 0; i < 5; i++) begin
      bus.BranchOut = 8'($urandom);
      cycle();
    end
    idle();
    total++;
    if (bus.ras_err !== 1'b1) begin
      $display("FAIL ras_overflow: got err=%b want 1", bus.ras_err); bad++;
    end
    do_reset();
    cycle();
    bus.ret = 1;
    cycle();
    idle();
    total++;
    if (bus.core !== 8'h01 || bus.ras_err !== 1'b1 || bus.taken !== 1'b0) begin
      $display("FAIL ras_underflow: got core=%h err=%b taken=%b want core=01 err=1 taken=0",
               bus.core, bus.ras_err, bus.taken); bad++;
    end
`else
    total++;
    if (bus.core !== 8'h41 || bus.taken !== 1'b0 || bus.ras_err !== 1'b0) begin
      $display("FAIL ret_ignored: got core=%h taken=%b err=%b want core=41 taken=0 err=0",
               bus.core, bus.taken, bus.ras_err); bad++;
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bus.halt       = ($urandom_range(0, 199) == 0);
      bus.stall      = ($urandom_range(0, 7) == 0);
      bus.branchsig  = 1'($urandom);
      bus.branchmode = 2'($urandom);
      bus.branchrel  = 1'($urandom);
      bus.BranchOut  = 8'($urandom);
      bus.cmp        = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus.call       = ($urandom_range(0, 7) == 0);
      bus.ret        = ($urandom_range(0, 7) == 0);
      cycle();
      total++;
      if (outs() !== expv()) begin
        $display("FAIL random[%0d]: got %h want %h", i, outs(), expv()); bad++;
      end
      if (m_state == 2 && $urandom_range(0, 3) == 0) do_reset();
    end
    idle();
  endtask

  task automatic test_reset_midway();
    do_reset();
    cycle();
`ifdef FETCH_RAS_EN
    bus.call = 1; bus.BranchOut = 8'h60;
    cycle();
    idle();
`endif
    goto_pc(8'h50);
    bus.branchsig = 1; bus.BranchOut = 8'h99;
    @(negedge clk);
    reset = 0;
    model_reset();
    #1;
    total++;
    if (bus.core !== 8'h00 || bus.fetch_cnt !== 16'h0 || outs() !== expv()) begin
      $display("FAIL async_reset: got %h want %h", outs(), expv()); bad++;
    end
    idle();
    repeat (2) cycle();
    reset = 1;
    cycle();
`ifdef FETCH_RAS_EN
    bus.ret = 1;
    cycle();
    idle();
    total++;
    if (bus.core !== 8'h01 || bus.ras_err !== 1'b1) begin
      $display("FAIL ras_cleared: got core=%h err=%b want core=01 err=1",
               bus.core, bus.ras_err); bad++;
    end
`else
    cycle();
    total++;
    if (bus.core !== 8'h01 || bus.fetch_cnt !== 16'h1) begin
      $display("FAIL restart_after_reset: got core=%h cnt=%h want core=01 cnt=0001",
               bus.core, bus.fetch_cnt); bad++;
    end
`endif
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_boot();
    test_branch_cond();
    test_rel_wrap();
    test_stall_halt();
    test_call_ret();
    test_random();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
